// File: rtl/serial_lsb_comparator_pkg.sv
// -----------------------------------------------------------------------------
// serial_lsb_comparator_pkg
//   Shared definitions for the serial LSB-first magnitude comparator:
//   FSM state encoding, flag-vector layout and the one-hot flag constants
//   used by both the top level and the digit compare slice.
// -----------------------------------------------------------------------------
package serial_lsb_comparator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // Bit positions of the individual result flags inside flags_t.
    localparam int FLG_GT    = 2;
    localparam int FLG_EQ    = 1;
    localparam int FLG_LT    = 0;
    localparam int NUM_FLAGS = 3;

    typedef logic [NUM_FLAGS-1:0] flags_t;

    localparam flags_t FLAGS_NONE = '0;
    localparam flags_t FLAGS_GT   = flags_t'(1) << FLG_GT;
    localparam flags_t FLAGS_EQ   = flags_t'(1) << FLG_EQ;
    localparam flags_t FLAGS_LT   = flags_t'(1) << FLG_LT;

endpackage

// File: rtl/serial_lsb_comparator_digit_cmp.sv
// -----------------------------------------------------------------------------
// serial_lsb_comparator_digit_cmp
//   Combinational compare of one DIGIT-bit slice of the operands. Because the
//   scan runs LSB -> MSB, any unequal digit simply overwrites the running
//   result; an equal digit passes the previous result through.
//
// Ports
//   prev_flags   in   3       running {gt,eq,lt} from less significant digits
//   digit_a      in   DIGIT   current digit of operand A
//   digit_b      in   DIGIT   current digit of operand B
//   msb_signed   in   1       this is the top digit of a two's-complement compare
//   next_flags   out  3       updated {gt,eq,lt}
// -----------------------------------------------------------------------------
module serial_lsb_comparator_digit_cmp
    import serial_lsb_comparator_pkg::*;
#(
    parameter int DIGIT = 1
) (
    input  flags_t           prev_flags,
    input  logic [DIGIT-1:0] digit_a,
    input  logic [DIGIT-1:0] digit_b,
    input  logic             msb_signed,
    output flags_t           next_flags
);

    logic sign_differs;

    assign sign_differs = msb_signed && (digit_a[DIGIT-1] != digit_b[DIGIT-1]);

    always_comb begin
        // NOTE: default assignment first, so every path writes next_flags and
        // no latch is inferred.
        next_flags = prev_flags;
        if (sign_differs) begin
            // A negative sign bit makes A the smaller operand, the opposite of
            // the unsigned sense. With equal sign bits the plain unsigned
            // compare of the digit is already correct.
            next_flags = digit_a[DIGIT-1] ? FLAGS_LT : FLAGS_GT;
        end else if (digit_a > digit_b) begin
            next_flags = FLAGS_GT;
        end else if (digit_a < digit_b) begin
            next_flags = FLAGS_LT;
        end
    end

endmodule

// File: rtl/serial_lsb_comparator.sv
// -----------------------------------------------------------------------------
// serial_lsb_comparator
//   Multi-cycle magnitude comparator. Operands are captured on a valid/ready
//   handshake, then scanned LSB -> MSB, DIGIT bits per cycle; more significant
//   digits override less significant ones. The result is held with outvalid
//   until the consumer raises inpready.
//
// Parameters
//   WIDTH   operand width in bits
//   DIGIT   bits compared per cycle (WIDTH must be a multiple of DIGIT)
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   inpvalid   in   1      operand request valid
//   outready   out  1      operands accepted (high only in IDLE)
//   inpa       in   WIDTH  operand A
//   inpb       in   WIDTH  operand B
//   inpsigned  in   1      1 = two's-complement compare, 0 = unsigned
//   outvalid   out  1      result valid (high only in DONE)
//   inpready   in   1      consumer accepts the result
//   outgt      out  1      A > B
//   outeq      out  1      A == B
//   outlt      out  1      A < B
// -----------------------------------------------------------------------------
module serial_lsb_comparator
    import serial_lsb_comparator_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inpvalid,
    output logic             outready,
    input  logic [WIDTH-1:0] inpa,
    input  logic [WIDTH-1:0] inpb,
    input  logic             inpsigned,
    output logic             outvalid,
    input  logic             inpready,
    output logic             outgt,
    output logic             outeq,
    output logic             outlt
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    generate
        if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_digit
            $error("serial_lsb_comparator: WIDTH must be a positive multiple of DIGIT");
        end
    endgenerate

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             signed_q;
    flags_t           flags;
    flags_t           flags_next;
    logic             msb_signed;

    // The sign rule only applies to the digit holding bit WIDTH-1.
    assign msb_signed = signed_q && (count == LAST);

    serial_lsb_comparator_digit_cmp #(
        .DIGIT (DIGIT)
    ) u_digit_cmp (
        .prev_flags (flags),
        .digit_a    (a_q[DIGIT-1:0]),
        .digit_b    (b_q[DIGIT-1:0]),
        .msb_signed (msb_signed),
        .next_flags (flags_next)
    );

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            count    <= '0;
            // NOTE: the operand copies are reset along with the control state;
            // they are few flops and it keeps the datapath free of X after reset.
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            flags    <= FLAGS_NONE;
            outvalid <= 1'b0;
            outready <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (inpvalid && outready) begin
                        a_q      <= inpa;
                        b_q      <= inpb;
                        signed_q <= inpsigned;
                        flags    <= FLAGS_EQ;
                        count    <= '0;
                        outready <= 1'b0;
                        state    <= ST_COMPARE;
                    end
                end

                ST_COMPARE: begin
                    flags <= flags_next;
                    // Shifting brings the next digit to the bottom, so the
                    // compare slice always looks at bits [DIGIT-1:0].
                    a_q   <= a_q >> DIGIT;
                    b_q   <= b_q >> DIGIT;
                    if (count == LAST) begin
                        outvalid <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end

                ST_DONE: begin
                    if (inpready) begin
                        outvalid <= 1'b0;
                        outready <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end

                default: begin
                    outvalid <= 1'b0;
                    outready <= 1'b1;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign outgt = flags[FLG_GT];
    assign outeq = flags[FLG_EQ];
    assign outlt = flags[FLG_LT];

endmodule
